alu_seq: RTL and testbench

Parametrised, handshaked successor to the processor's combinational ALU. Executes add, nor, nori, not, bleu, rolv and rorv on WIDTH-bit operands. Single-cycle ops return a registered result one cycle after acceptance. Rotates run iteratively, one bit position per cycle. Sits between the decode/register-read stage and writeback, and stalls the pipeline through valid/ready.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_seq_comb.sv | 54 +++++
 rtl/alu_seq.sv | 198 +++++++++++++++++++
 tb/tb_alu_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the sequential ALU. Holds the opcode
//                encodings (also imported by the decode stage), the control
//                FSM state type and a helper that classifies rotate opcodes.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b10000;
   localparam logic [4:0] OP_NOR  = 5'b10011;
   localparam logic [4:0] OP_NORI = 5'b00111;
   localparam logic [4:0] OP_NOT  = 5'b00010;
   localparam logic [4:0] OP_BLEU = 5'b01000;
   localparam logic [4:0] OP_ROLV = 5'b00000;
   localparam logic [4:0] OP_RORV = 5'b00001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ROT  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True for the two variable-rotate opcodes, which may need the
   // iterative path depending on the rotate amount.
   function automatic logic is_rot(input logic [4:0] sel);
      return (sel == OP_ROLV) || (sel == OP_RORV);
   endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_seq_comb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_comb
//  Description : Purely combinational single-cycle datapath of the sequential
//                ALU. Produces the result of every non-iterative operation.
//                Rotate opcodes return I1 unchanged here: that is the correct
//                answer for a rotate by zero, and non-zero rotates are handled
//                by the iterative path in the top level.
//  Ports       : I1, I2    - WIDTH-bit operands
//                Selector  - 5-bit opcode
//                res       - WIDTH-bit result
//                cout      - carry out of add, 0 otherwise
//                bad_op    - Selector is not a defined opcode
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I2,
   input  logic [4:0]       Selector,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             bad_op
);

   logic [WIDTH:0] sum;

   // One extra bit captures the carry out of the addition.
   assign sum = {1'b0, I1} + {1'b0, I2};

   always_comb begin
      res    = '0;
      cout   = 1'b0;
      bad_op = 1'b0;
      case (Selector)
         OP_ADD: begin
            res  = sum[WIDTH-1:0];
            cout = sum[WIDTH];
         end
         OP_NOR,
         OP_NORI: res = ~(I1 | I2);
         OP_NOT:  res = ~I1;
         OP_BLEU: res = {{(WIDTH-1){1'b0}}, (I1 <= I2)};
         OP_ROLV,
         OP_RORV: res = I1;
         default: bad_op = 1'b1;
      endcase
   end

endmodule : alu_seq_comb
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked sequential ALU. Single-cycle operations register
//                their result at the accepting edge; variable rotates iterate
//                one bit position per cycle through an accumulator. Results
//                are held on O until the consumer takes them.
//  Ports       : clk        - rising-edge clock
//                reset      - synchronous, active-high
//                in_valid   - operation offered
//                in_ready   - block can accept this cycle
//                I1, I2     - operands (I2 low SHW bits = rotate amount)
//                Selector   - opcode
//                out_valid  - result held on O
//                out_ready  - consumer takes result
//                O          - result
//                cout       - carry out of add, 0 for other ops
//                bad_op     - Selector was not a defined opcode
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I2,
   input  logic [4:0]       Selector,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] O,
   output logic             cout,
   output logic             bad_op
);

   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] comb_res;
   logic             comb_cout;
   logic             comb_bad;

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_step;
   logic [SHW-1:0]   cnt;
   logic             dir_right;

   logic [WIDTH-1:0] result;
   logic             carry;
   logic             bad;

   logic             accept;
   logic [SHW-1:0]   amount;
   logic             start_rot;

   // ------------------------------------------------------------------------
   // Single-cycle datapath
   // ------------------------------------------------------------------------
   alu_seq_comb #(
      .WIDTH    (WIDTH)
   ) u_comb (
      .I1       (I1),
      .I2       (I2),
      .Selector (Selector),
      .res      (comb_res),
      .cout     (comb_cout),
      .bad_op   (comb_bad)
   );

   // ------------------------------------------------------------------------
   // Accept decode
   // ------------------------------------------------------------------------
   assign accept = in_valid & in_ready;

   // Rotate amounts are taken modulo WIDTH; upper bits of I2 are ignored.
   assign amount = I2[SHW-1:0];

   // A rotate by zero is just "return I1", so only non-zero rotates go
   // through the iterative path.
   assign start_rot = is_rot(Selector) && (amount != '0);

   // One-position rotate of the accumulator in the latched direction.
   always_comb begin
      if (dir_right) begin
         acc_step = {acc[0], acc[WIDTH-1:1]};
      end else begin
         acc_step = {acc[WIDTH-2:0], acc[WIDTH-1]};
      end
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = start_rot ? ST_ROT : ST_DONE;
            end
         end
         ST_ROT: begin
            // The rotate performed while cnt == 1 is the last one.
            if (cnt == CNT_ONE) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            // A simultaneous retire + accept behaves as an accept from IDLE.
            if (accept) begin
               state_nxt = start_rot ? ST_ROT : ST_DONE;
            end else if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs. out_ready -> in_ready in DONE is the only combinational
   // path through the block; it lets results stream at one per cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: in_ready = 1'b1;
         ST_ROT:  in_ready = 1'b0;
         ST_DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers. Operands are only sampled at accept; the result
   // registers change only when a new result is complete, so O never shows a
   // partial rotate.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         dir_right <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         bad       <= 1'b0;
      end else if (accept) begin
         if (start_rot) begin
            acc       <= I1;
            cnt       <= amount;
            dir_right <= (Selector == OP_RORV);
         end else begin
            result <= comb_res;
            carry  <= comb_cout;
            bad    <= comb_bad;
         end
      end else if (state == ST_ROT) begin
         acc <= acc_step;
         cnt <= cnt - CNT_ONE;
         if (cnt == CNT_ONE) begin
            result <= acc_step;
            carry  <= 1'b0;
            bad    <= 1'b0;
         end
      end
   end

   assign O      = result;
   assign cout   = carry;
   assign bad_op = bad;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq (WIDTH = 32). Directed cases
//                followed by randomized operations, compared against an
//                arithmetic reference model of the opcode rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] I1;
   logic [31:0] I2;
   logic [4:0]  Selector;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] O;
   logic        cout;
   logic        bad_op;

   int n_total;
   int n_bad;

   alu_seq #(
      .WIDTH     (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .I1        (I1),
      .I2        (I2),
      .Selector  (Selector),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .O         (O),
      .cout      (cout),
      .bad_op    (bad_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: result, carry, bad-op flag and the number of clock
   // edges after the accepting edge before the result is presented
   // (zero for single-cycle ops, the rotate amount for non-zero rotates).
   task automatic ref_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output logic e, output int lat);
      logic [63:0] w;
      logic [32:0] s;
      int          amt;
      r   = 32'h0;
      c   = 1'b0;
      e   = 1'b0;
      lat = 0;
      amt = int'(b % 32);
      case (sel)
         5'b10000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
         5'b10011, 5'b00111: r = ~(a | b);
         5'b00010: r = ~a;
         5'b01000: r = (a <= b) ? 32'd1 : 32'd0;
         5'b00000: begin w = {a, a} << amt; r = w[63:32]; lat = amt; end
         5'b00001: begin w = {a, a} >> amt; r = w[31:0];  lat = amt; end
         default:  e = 1'b1;
      endcase
   endtask

   // Issue one op from IDLE, wait for its result, hold it for 'hold' cycles
   // of backpressure, then retire it.
   task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      logic [31:0] er;
      logic        ec, eb;
      int          elat, lat;
      logic        saw_ready;
      ref_op(sel, a, b, er, ec, eb, elat);
      in_valid = 1'b1;
      Selector = sel;
      I1       = a;
      I2       = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Scramble operands: they must have been captured at accept.
      I1       = $urandom;
      I2       = $urandom;
      Selector = 5'($urandom);
      lat       = 0;
      saw_ready = 1'b0;
      while (!out_valid && lat < 64) begin
         if (in_ready) saw_ready = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      check_val({tag, "_lat"}, 64'(lat), 64'(elat));
      check_val({tag, "_O"}, 64'(O), 64'(er));
      check_val({tag, "_cout"}, 64'(cout), 64'(ec));
      check_val({tag, "_bad"}, 64'(bad_op), 64'(eb));
      if (elat > 0) check_val({tag, "_rdy_rot"}, 64'(saw_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_val({tag, "_hold_v"}, 64'(out_valid), 64'd1);
         check_val({tag, "_hold_O"}, 64'(O), 64'(er));
         check_val({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val({tag, "_retire_v"}, 64'(out_valid), 64'd0);
      check_val({tag, "_retire_rdy"}, 64'(in_ready), 64'd1);
   endtask

   logic [4:0]  ops [7];
   logic [31:0] q_res [$];

   initial begin
      logic [4:0]  sel;
      logic [31:0] a, b, er;
      logic        ec, eb;
      int          elat;

      ops[0] = 5'b10000; ops[1] = 5'b10011; ops[2] = 5'b00111; ops[3] = 5'b00010;
      ops[4] = 5'b01000; ops[5] = 5'b00000; ops[6] = 5'b00001;
      n_total   = 0;
      n_bad     = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      I1        = '0;
      I2        = '0;
      Selector  = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_val("rst_v", 64'(out_valid), 64'd0);
      check_val("rst_rdy", 64'(in_ready), 64'd1);
      check_val("rst_O", 64'(O), 64'd0);
      check_val("rst_cout", 64'(cout), 64'd0);
      check_val("rst_bad", 64'(bad_op), 64'd0);

      // Directed cases
      run_op("add_ovf", 5'b10000, 32'hFFFF_FFFF, 32'h1, 0);
      run_op("nor", 5'b10011, 32'h0F0F_0000, 32'h00F0_000F, 0);
      run_op("nori", 5'b00111, 32'h1234_5678, 32'h0000_FFFF, 1);
      run_op("not0", 5'b00010, 32'h0, 32'h5, 0);
      run_op("bleu_eq", 5'b01000, 32'h5, 32'h5, 0);
      run_op("bleu_gt", 5'b01000, 32'h8000_0000, 32'h7, 0);
      run_op("rolv4", 5'b00000, 32'h8000_0001, 32'h4, 0);
      run_op("rorv4", 5'b00001, 32'h8000_0001, 32'h4, 0);
      run_op("rolv32", 5'b00000, 32'hDEAD_BEEF, 32'd32, 0);
      run_op("rorv31", 5'b00001, 32'h0000_0003, 32'hFFFF_FFFF, 0);
      run_op("badop", 5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

      // Backpressure, then retire + accept in the same cycle
      in_valid = 1'b1; Selector = 5'b10000; I1 = 32'h0000_0010; I2 = 32'h0000_0020;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_val("bp_v0", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_val("bp_v", 64'(out_valid), 64'd1);
         check_val("bp_O", 64'(O), 64'h30);
         check_val("bp_rdy", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1; in_valid = 1'b1; Selector = 5'b00010; I1 = 32'h3;
      #1 check_val("bp_rdy_comb", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_val("bp_new_v", 64'(out_valid), 64'd1);
      check_val("bp_new_O", 64'(O), 64'hFFFF_FFFC);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val("bp_end_v", 64'(out_valid), 64'd0);

      // Streaming: 8 single-cycle ops, one result per cycle, in order
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sel = ops[$urandom_range(0, 4)];
         if (k == 5) sel = 5'b00000;
         a = $urandom;
         b = (k == 5) ? 32'd64 : $urandom;
         ref_op(sel, a, b, er, ec, eb, elat);
         q_res.push_back(er);
         in_valid = 1'b1; Selector = sel; I1 = a; I2 = b;
         @(posedge clk); #1;
         check_val("str_v", 64'(out_valid), 64'd1);
         check_val("str_O", 64'(O), 64'(q_res.pop_front()));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val("str_end_v", 64'(out_valid), 64'd0);

      // Reset in the middle of a rotate
      in_valid = 1'b1; Selector = 5'b00000; I1 = 32'hA5A5_0F0F; I2 = 32'd20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      check_val("mid_v", 64'(out_valid), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_val("mrst_v", 64'(out_valid), 64'd0);
      check_val("mrst_O", 64'(O), 64'd0);
      check_val("mrst_rdy", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      check_val("mrst_v2", 64'(out_valid), 64'd0);

      // Randomized operations with random backpressure
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) sel = 5'($urandom);
         else                           sel = ops[$urandom_range(0, 6)];
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF;
         run_op("rnd", sel, a, b, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_alu_seq
`default_nettype wire
